serial_load_sequencer: RTL and testbench

//  - Serializes parallel config words onto a slow serial bus: sdata, sclk, and a latch strobe.
//  - Drives the on-chip serial shift receivers, which sample sclk on the same clk.
//  - Sits between the register/config front end and the shift-register chain.
//  - Words go out LSB first: after WIDTH pulses, bit 0 sits at receiver bit 0.

---
 rtl/serial_seq_pkg.sv | 16 +
 rtl/sclk_phase_timer.sv | 31 +++
 rtl/serial_load_sequencer.sv | 151 +++++++++++++++
 tb/tb_serial_load_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_seq_pkg.sv
// Shared types and width helpers for the serial load sequencer.
package serial_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

  // Index width able to address n bits, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Down-counter width able to hold half_period-1, never narrower than one bit.
  function automatic int unsigned half_cnt_w(input int unsigned half_period);
    return (half_period <= 32'd1) ? 32'd1 : 32'($clog2(half_period));
  endfunction

endpackage

// File: rtl/sclk_phase_timer.sv
// Loadable down-counter that times one sclk phase of HALF_PERIOD clk cycles.
module sclk_phase_timer
  import serial_seq_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic phase_done_c
);

  localparam int unsigned CW = half_cnt_w(HALF_PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // High on the last cycle of the current phase.
  assign phase_done_c = (cnt == '0);

endmodule

// File: rtl/serial_load_sequencer.sv
// Serializes parallel config words LSB first onto sclk/sdata and strobes latch per word.
// Optional readback of the previous chain contents via sdin when SEQ_READBACK_EN is defined.
module serial_load_sequencer
  import serial_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned HALF_PERIOD = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
`ifdef SEQ_READBACK_EN
  ,
  input  logic             sdin,
  output logic [WIDTH-1:0] rb_data,
  output logic             rb_valid
`endif
);

  localparam int unsigned IDX_W = idx_w(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] word_nxt;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] bit_idx_nxt;
  logic             sdata_nxt;
  logic             phase_done_c;
  logic             timer_load_c;

  // Every state change restarts the phase timer.
  assign timer_load_c = (state_nxt != state);

  sclk_phase_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .load        (timer_load_c),
    .phase_done_c(phase_done_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    word_nxt    = word;
    bit_idx_nxt = bit_idx;
    sdata_nxt   = sdata;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt   = LOW;
          word_nxt    = in_data;
          bit_idx_nxt = '0;
        end
      end
      LOW: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (phase_done_c) begin
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (phase_done_c) begin
          if (bit_idx == LAST_IDX) begin
            state_nxt = LATCH;
          end else begin
            state_nxt   = LOW;
            bit_idx_nxt = bit_idx + IDX_W'(1);
          end
        end
      end
      LATCH: begin
        // Latch is already committed, so abort cannot cancel it here.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // sdata changes only when a low phase begins, so it is stable across the whole pulse.
    if (state_nxt == LOW) begin
      sdata_nxt = word_nxt[bit_idx_nxt];
    end
  end

  // Outputs are flopped from the next state so nothing combinational reaches the pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word       <= '0;
      bit_idx    <= '0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      latch      <= 1'b0;
      busy       <= 1'b0;
      in_ready   <= 1'b1;
      words_sent <= '0;
    end else begin
      word     <= word_nxt;
      bit_idx  <= bit_idx_nxt;
      sdata    <= sdata_nxt;
      sclk     <= (state_nxt == HIGH);
      latch    <= (state_nxt == LATCH);
      busy     <= (state_nxt != IDLE);
      in_ready <= (state_nxt == IDLE);
      if (state_nxt == LATCH) begin
        words_sent <= words_sent + CNT_W'(1);
      end
    end
  end

`ifdef SEQ_READBACK_EN
  // The chain's old bits return on sdin; capture each one as its high phase ends.
  logic sample_c;
  assign sample_c = (state == HIGH) && phase_done_c && !abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= (state_nxt == LATCH);
      if (sample_c) begin
        rb_data <= {sdin, rb_data[WIDTH-1:1]};
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_load_sequencer.sv
// Bench for serial_load_sequencer: directed and random words against a receiver-chain model.
module tb_serial_load_sequencer;

  localparam int A_CNT_MOD = 65536;
  localparam int B_CNT_MOD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int exp_ws_a = 0;
  int exp_ws_b = 0;

  logic        a_rst, a_in_valid, a_in_ready, a_abort, a_sclk, a_sdata, a_latch, a_busy;
  logic [7:0]  a_in_data;
  logic [15:0] a_words_sent;
  logic        b_rst, b_in_valid, b_in_ready, b_abort, b_sclk, b_sdata, b_latch, b_busy;
  logic [7:0]  b_in_data;
  logic [1:0]  b_words_sent;
`ifdef SEQ_READBACK_EN
  logic        a_sdin, a_rb_valid, b_sdin, b_rb_valid;
  logic [7:0]  a_rb_data, b_rb_data;
`endif

  serial_load_sequencer #(.WIDTH(8), .HALF_PERIOD(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(a_rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .abort(a_abort), .sclk(a_sclk), .sdata(a_sdata),
    .latch(a_latch), .busy(a_busy), .words_sent(a_words_sent)
`ifdef SEQ_READBACK_EN
    , .sdin(a_sdin), .rb_data(a_rb_data), .rb_valid(a_rb_valid)
`endif
  );

  serial_load_sequencer #(.WIDTH(8), .HALF_PERIOD(1), .CNT_W(2)) dut_b (
    .clk(clk), .reset(b_rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .abort(b_abort), .sclk(b_sclk), .sdata(b_sdata),
    .latch(b_latch), .busy(b_busy), .words_sent(b_words_sent)
`ifdef SEQ_READBACK_EN
    , .sdin(b_sdin), .rb_data(b_rb_data), .rb_valid(b_rb_valid)
`endif
  );

  // Downstream 8-bit shift chain: shifts in on the sclk fall, serial out is bit 0.
  logic [7:0] rx_a = 8'h00;
  logic       rx_prev = 1'b0;
  logic       rx_held = 1'b0;
  logic       rx_load = 1'b0;
  logic [7:0] rx_load_val = 8'h00;
  always @(posedge clk) begin
    rx_prev <= a_sclk;
    if (a_sclk) rx_held <= a_sdata;
    if (rx_load) rx_a <= rx_load_val;
    else if (rx_prev && !a_sclk) rx_a <= {rx_held, rx_a[7:1]};
  end
`ifdef SEQ_READBACK_EN
  assign a_sdin = rx_a[0];
  assign b_sdin = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Send one word on dut_a and check it pulse by pulse; optional abort or reset mid-word.
  task automatic send_a(input logic [7:0] w, input int abort_pulse, input int reset_pulse,
                        input bit abort_acc);
    int n, acc_edge, pulses, hi_len, seen;
    logic prev, cur_bit;
    bit done;
`ifdef SEQ_READBACK_EN
    logic [7:0] rb_exp;
`endif
    @(negedge clk);
    a_in_data = w;
    a_in_valid = 1'b1;
    n = 0;
    while (!a_in_ready && n < 100) begin @(negedge clk); n++; end
    a_abort = abort_acc;
    acc_edge = cyc + 1;
`ifdef SEQ_READBACK_EN
    rb_exp = rx_a;
`endif
    @(negedge clk);
    a_in_valid = 1'b0;
    a_abort = 1'b0;
    a_in_data = ~w;
    check("accept_busy", a_busy, 1);
    check("accept_ready_low", a_in_ready, 0);
    pulses = 0; hi_len = 0; prev = 1'b0; cur_bit = 1'b0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (a_sclk && !prev) begin
        pulses++;
        hi_len = 0;
        cur_bit = a_sdata;
        if (pulses <= 8) check("sdata_bit", a_sdata, w[pulses-1]);
      end
      if (a_sclk) begin
        hi_len++;
        if (hi_len > 1) check("sdata_stable", a_sdata, cur_bit);
      end
      if (!a_sclk && prev) check("high_len", hi_len, 2);
      if (abort_pulse != 0 && a_sclk && !prev && pulses == abort_pulse) begin
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        check("abort_sclk_low", a_sclk, 0);
        check("abort_ready", a_in_ready, 1);
        check("abort_busy_low", a_busy, 0);
        seen = 0;
        repeat (40) begin seen += int'(a_latch); @(negedge clk); end
        check("abort_no_latch", seen, 0);
        check("abort_words_sent", a_words_sent, exp_ws_a);
        return;
      end
      if (reset_pulse != 0 && a_sclk && !prev && pulses == reset_pulse) begin
        #2 a_rst = 1'b0;
        #1;
        check("rst_sclk", a_sclk, 0);
        check("rst_sdata", a_sdata, 0);
        check("rst_latch", a_latch, 0);
        check("rst_busy", a_busy, 0);
        check("rst_words_sent", a_words_sent, 0);
        check("rst_in_ready", a_in_ready, 1);
        exp_ws_a = 0;
        @(negedge clk);
        a_rst = 1'b1;
        return;
      end
      if (a_latch) begin
        check("latch_latency", cyc - acc_edge, 32);
        check("pulse_count", pulses, 8);
        exp_ws_a = (exp_ws_a + 1) % A_CNT_MOD;
        check("words_sent", a_words_sent, exp_ws_a);
`ifdef SEQ_READBACK_EN
        check("rb_valid", a_rb_valid, 1);
        check("rb_data", a_rb_data, rb_exp);
`endif
        @(negedge clk);
        check("latch_one_cycle", a_latch, 0);
        check("rx_word", rx_a, w);
        done = 1'b1;
      end else begin
        prev = a_sclk;
        @(negedge clk);
      end
    end
    check("latch_seen", done, 1);
  endtask

  // Send one word on dut_b (HALF_PERIOD=1, 2-bit counter) and check latency and count.
  task automatic send_b(input logic [7:0] w);
    int n, acc_edge;
    @(negedge clk);
    b_in_data = w;
    b_in_valid = 1'b1;
    n = 0;
    while (!b_in_ready && n < 100) begin @(negedge clk); n++; end
    acc_edge = cyc + 1;
    @(negedge clk);
    b_in_valid = 1'b0;
    n = 0;
    while (!b_latch && n < 100) begin @(negedge clk); n++; end
    check("b_latch_latency", cyc - acc_edge, 16);
    exp_ws_b = (exp_ws_b + 1) % B_CNT_MOD;
    check("b_words_sent", b_words_sent, exp_ws_b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc;
    logic [7:0] w;
    a_rst = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00; a_abort = 1'b0;
    b_rst = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00; b_abort = 1'b0;
    repeat (3) @(negedge clk);
    a_rst = 1'b1;
    b_rst = 1'b1;
    @(negedge clk);
    check("reset_sclk", a_sclk, 0);
    check("reset_sdata", a_sdata, 0);
    check("reset_latch", a_latch, 0);
    check("reset_busy", a_busy, 0);
    check("reset_words_sent", a_words_sent, 0);
    check("reset_in_ready", a_in_ready, 1);
    check("reset_b_words_sent", b_words_sent, 0);
    check("reset_b_in_ready", b_in_ready, 1);

    // Back-to-back 0x01 then 0xFF with in_valid held high.
    a_in_data = 8'h01;
    a_in_valid = 1'b1;
    n = 0;
    while (!a_latch && n < 200) begin @(negedge clk); n++; end
    check("b2b_first_latch", a_latch, 1);
    exp_ws_a++;
    a_in_data = 8'hFF;
    @(negedge clk);
    check("b2b_ready_after_latch", a_in_ready, 1);
    acc = cyc + 1;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("b2b_second_accept", a_busy, 1);
    n = 0;
    while (!a_latch && n < 200) begin @(negedge clk); n++; end
    check("b2b_second_latency", cyc - acc, 32);
    exp_ws_a++;
    check("b2b_words_sent", a_words_sent, exp_ws_a);
    @(negedge clk);
    check("b2b_rx", rx_a, 8'hFF);

    send_a(8'hA5, 0, 0, 1'b0);
    send_a(8'h96, 0, 0, 1'b1);
    send_a(8'h3C, 3, 0, 1'b0);
    send_a(8'hF0, 0, 5, 1'b0);
    send_a(8'h5A, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      w = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_a(w, 0, 0, 1'b0);
    end

`ifdef SEQ_READBACK_EN
    @(negedge clk);
    rx_load_val = 8'hC3;
    rx_load = 1'b1;
    @(negedge clk);
    rx_load = 1'b0;
    send_a(8'h00, 0, 0, 1'b0);
    check("rb_c3_hold", a_rb_data, 8'hC3);
`endif

    for (int i = 0; i < 5; i++) send_b(8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
